// File: rtl/pkt_pkg.sv
// Purpose : shared types and constants for the packet deframer slice.
// Contents: FSM state enum, errCode values, header field positions,
//           default sync word.
package pkt_pkg;

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    PAY  = 2'd1,
    FTR  = 2'd2,
    DROP = 2'd3
  } stateT;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_SYNC = 2'd1;
  localparam logic [1:0] ERR_LEN  = 2'd2;
  localparam logic [1:0] ERR_CSUM = 2'd3;

  // Header word layout: sync marker in the upper half, payload length below.
  localparam int SYNC_MSB = 31;
  localparam int SYNC_LSB = 16;
  localparam int LEN_MSB  = 15;
  localparam int LEN_LSB  = 0;

  localparam logic [15:0] DEFAULT_SYNC_WORD = 16'hCAFE;

endpackage

// File: rtl/sat_counter.sv
// Purpose : up-counter that sticks at all-ones instead of wrapping.
// Latency : count reflects an inc one edge after it is sampled.
// Backpressure: none; clear has priority over inc.
// Ports   : clock, clear (sync, active-high), inc, count[WIDTH-1:0].
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/packet_deframer.sv
// Purpose : strips header/footer from framed stream, checks sync, length
//           and XOR checksum, forwards payload with regenerated lastOut.
// Latency : one cycle input-to-output; all outputs registered.
// Backpressure: none; every valid word is consumed the cycle it arrives.
// Ports   : clock/reset; dataIn/validIn/lastIn framed input;
//           dataOut/validOut/lastOut payload output; pktDone/pktErr/errCode
//           per-frame status pulses; pktCount/errCount saturating counters.
module packet_deframer
  import pkt_pkg::*;
#(
  parameter int          DATA_WIDTH  = 32,
  parameter int          MAX_PAYLOAD = 381,
  parameter logic [15:0] SYNC_WORD   = DEFAULT_SYNC_WORD,
  parameter int          CNT_WIDTH   = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  validIn,
  input  logic                  lastIn,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  validOut,
  output logic                  lastOut,
  output logic                  pktDone,
  output logic                  pktErr,
  output logic [1:0]            errCode,
  output logic [CNT_WIDTH-1:0]  pktCount,
  output logic [CNT_WIDTH-1:0]  errCount
);

  localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);

  stateT                 state;
  logic [15:0]           remaining;
  logic [DATA_WIDTH-1:0] csumAcc;

  logic [15:0] hdrSync;
  logic [15:0] hdrLen;
  logic        doneEvt;
  logic        errEvt;
  logic [1:0]  errKind;

  assign hdrSync = dataIn[SYNC_MSB:SYNC_LSB];
  assign hdrLen  = dataIn[LEN_MSB:LEN_LSB];

  // Frame verdict for the word being sampled. Decoded combinationally so the
  // status pulse and the counter bump land on the same edge.
  always_comb begin
    doneEvt = 1'b0;
    errEvt  = 1'b0;
    errKind = ERR_NONE;
    if (validIn) begin
      case (state)
        HDR: begin
          if (hdrSync != SYNC_WORD) begin
            errEvt  = 1'b1;
            errKind = ERR_SYNC;
          end else if ((hdrLen == 16'd0) || (hdrLen > MAX_LEN) || lastIn) begin
            // A good header that also ends the frame is a zero-content frame.
            errEvt  = 1'b1;
            errKind = ERR_LEN;
          end
        end
        PAY: begin
          if (lastIn) begin
            errEvt  = 1'b1;
            errKind = ERR_LEN;
          end
        end
        FTR: begin
          if (!lastIn) begin
            errEvt  = 1'b1;
            errKind = ERR_LEN;
          end else if (dataIn == csumAcc) begin
            doneEvt = 1'b1;
          end else begin
            errEvt  = 1'b1;
            errKind = ERR_CSUM;
          end
        end
        default: ;  // DROP reports nothing; the error was already flagged.
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= HDR;
      remaining <= '0;
      csumAcc   <= '0;
      dataOut   <= '0;
      validOut  <= 1'b0;
      lastOut   <= 1'b0;
      pktDone   <= 1'b0;
      pktErr    <= 1'b0;
      errCode   <= ERR_NONE;
    end else begin
      validOut <= 1'b0;
      lastOut  <= 1'b0;
      pktDone  <= doneEvt;
      pktErr   <= errEvt;
      errCode  <= errKind;
      if (validIn) begin
        case (state)
          HDR: begin
            if (errEvt) begin
              // Skip the rest of a rejected frame unless it already ended here.
              state <= lastIn ? HDR : DROP;
            end else begin
              remaining <= hdrLen;
              csumAcc   <= '0;
              state     <= PAY;
            end
          end
          PAY: begin
            dataOut   <= dataIn;
            validOut  <= 1'b1;
            csumAcc   <= csumAcc ^ dataIn;
            remaining <= remaining - 16'd1;
            if (lastIn) begin
              // Truncated: still close the downstream packet cleanly.
              lastOut <= 1'b1;
              state   <= HDR;
            end else if (remaining == 16'd1) begin
              lastOut <= 1'b1;
              state   <= FTR;
            end
          end
          FTR:  state <= lastIn ? HDR : DROP;
          DROP: if (lastIn) state <= HDR;
          default: state <= HDR;
        endcase
      end
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) uPktCount (
    .clock (clock),
    .clear (reset),
    .inc   (doneEvt),
    .count (pktCount)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) uErrCount (
    .clock (clock),
    .clear (reset),
    .inc   (errEvt),
    .count (errCount)
  );

endmodule

// File: tb/tb_packet_deframer.sv
// Purpose : directed self-checking bench for packet_deframer.
// Latency : outputs sampled 1 time unit after the edge that registers them.
// Backpressure: none; inputs driven on the falling edge.
module tb_packet_deframer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] dataIn = '0;
  logic        validIn = 1'b0;
  logic        lastIn = 1'b0;
  logic [31:0] dataOut;
  logic        validOut;
  logic        lastOut;
  logic        pktDone;
  logic        pktErr;
  logic [1:0]  errCode;
  logic [15:0] pktCount;
  logic [15:0] errCount;

  int errors = 0;
  int checks = 0;

  // Running expectations for the debug counters.
  int expPkt = 0;
  int expErr = 0;

  // Observations collected over a stretch of cycles.
  int       obsCyc, obsFwd, obsBad, obsLast, obsLastIdx, obsDone, obsDoneIdx, obsErr;
  logic [1:0] obsErrCode;

  packet_deframer #(
    .DATA_WIDTH  (32),
    .MAX_PAYLOAD (381),
    .SYNC_WORD   (16'hCAFE),
    .CNT_WIDTH   (16)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .dataIn   (dataIn),
    .validIn  (validIn),
    .lastIn   (lastIn),
    .dataOut  (dataOut),
    .validOut (validOut),
    .lastOut  (lastOut),
    .pktDone  (pktDone),
    .pktErr   (pktErr),
    .errCode  (errCode),
    .pktCount (pktCount),
    .errCount (errCount)
  );

  always #5 clock = ~clock;

  task automatic sendWord(input logic [31:0] d, input logic l);
    @(negedge clock);
    dataIn  = d;
    validIn = 1'b1;
    lastIn  = l;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    @(negedge clock);
    validIn = 1'b0;
    lastIn  = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic clearObs();
    obsCyc = 0; obsFwd = 0; obsBad = 0; obsLast = 0; obsLastIdx = -100;
    obsDone = 0; obsDoneIdx = -100; obsErr = 0; obsErrCode = 2'd0;
  endtask

  // Record what the outputs show this cycle; expW is the payload expected if valid.
  task automatic sample(input logic [31:0] expW);
    if (validOut) begin
      obsFwd++;
      if (dataOut !== expW) obsBad++;
    end
    if (lastOut) begin obsLast++; obsLastIdx = obsCyc; end
    if (pktDone) begin obsDone++; obsDoneIdx = obsCyc; end
    if (pktErr) begin obsErr++; obsErrCode = errCode; end
    if (!pktErr && errCode !== 2'd0) obsBad++;
    obsCyc++;
  endtask

  // Drive a whole framed packet; the caller judges the collected observations.
  task automatic runFrame(input logic [15:0] len, input logic [31:0] base,
                          input int gapEvery, input logic badFooter, input logic footerLast);
    logic [31:0] acc, w;
    acc = '0;
    clearObs();
    sendWord({16'hCAFE, len}, 1'b0);
    sample(32'h0);
    for (int i = 0; i < int'(len); i++) begin
      if (gapEvery > 0 && (i % gapEvery) == gapEvery - 1) begin
        idle();
        sample(32'h0);
      end
      w = base + 32'(i) * 32'h9E3779B1;
      acc ^= w;
      sendWord(w, 1'b0);
      sample(w);
    end
    sendWord(acc ^ {31'h0, badFooter}, footerLast);
    sample(32'h0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({dataOut, validOut, lastOut, pktDone, pktErr, errCode, pktCount, errCount} !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h/%b%b%b%b/%0d/%0d/%0d required all zero",
               dataOut, validOut, lastOut, pktDone, pktErr, errCode, pktCount, errCount);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_good_frame();
    clearObs();
    sendWord(32'hCAFE0003, 1'b0); sample(32'h0);
    checks++;
    if (validOut !== 1'b0) begin errors++; $display("FAIL good_hdr_valid: got %b required 0", validOut); end
    sendWord(32'h11111111, 1'b0); sample(32'h11111111);
    checks++;
    if ({validOut, lastOut, dataOut} !== {2'b10, 32'h11111111}) begin
      errors++; $display("FAIL good_word0: got v%b l%b %h required v1 l0 11111111", validOut, lastOut, dataOut);
    end
    sendWord(32'h22222222, 1'b0); sample(32'h22222222);
    sendWord(32'h44444444, 1'b0); sample(32'h44444444);
    checks++;
    if ({validOut, lastOut, dataOut} !== {2'b11, 32'h44444444}) begin
      errors++; $display("FAIL good_word2_last: got v%b l%b %h required v1 l1 44444444", validOut, lastOut, dataOut);
    end
    sendWord(32'h77777777, 1'b1); sample(32'h0);
    expPkt++;
    checks++;
    if ({pktDone, pktErr, validOut} !== 3'b100 || pktCount !== 16'(expPkt)) begin
      errors++; $display("FAIL good_footer: got done%b err%b v%b cnt%0d required done1 err0 v0 cnt%0d",
                         pktDone, pktErr, validOut, pktCount, expPkt);
    end
    checks++;
    if (obsFwd != 3 || obsBad != 0 || obsDoneIdx != obsLastIdx + 1) begin
      errors++; $display("FAIL good_timing: got fwd%0d bad%0d lastIdx%0d doneIdx%0d required fwd3 bad0 done=last+1",
                         obsFwd, obsBad, obsLastIdx, obsDoneIdx);
    end
  endtask

  task automatic test_checksum_error();
    clearObs();
    sendWord(32'hCAFE0003, 1'b0); sample(32'h0);
    sendWord(32'h11111111, 1'b0); sample(32'h11111111);
    sendWord(32'h22222222, 1'b0); sample(32'h22222222);
    sendWord(32'h44444444, 1'b0); sample(32'h44444444);
    sendWord(32'h77777776, 1'b1); sample(32'h0);
    expErr++;
    checks++;
    if ({pktErr, errCode, pktDone} !== 4'b1110 || errCount !== 16'(expErr) || pktCount !== 16'(expPkt)) begin
      errors++; $display("FAIL csum_status: got err%b code%0d done%b ec%0d pc%0d required err1 code3 done0 ec%0d pc%0d",
                         pktErr, errCode, pktDone, errCount, pktCount, expErr, expPkt);
    end
    checks++;
    if (obsFwd != 3 || obsBad != 0 || obsLast != 1) begin
      errors++; $display("FAIL csum_forward: got fwd%0d bad%0d last%0d required 3 0 1", obsFwd, obsBad, obsLast);
    end
  endtask

  task automatic test_bad_sync();
    clearObs();
    sendWord(32'hBEEF0005, 1'b0); sample(32'h0);
    checks++;
    if ({pktErr, errCode} !== 3'b101) begin
      errors++; $display("FAIL sync_pulse: got err%b code%0d required err1 code1", pktErr, errCode);
    end
    for (int i = 1; i <= 6; i++) begin
      sendWord(32'h5A5A0000 + 32'(i), i == 6); sample(32'h0);
    end
    expErr++;
    checks++;
    if (obsFwd != 0 || obsErr != 1 || obsBad != 0 || errCount !== 16'(expErr)) begin
      errors++; $display("FAIL sync_drop: got fwd%0d errs%0d bad%0d ec%0d required 0 1 0 %0d",
                         obsFwd, obsErr, obsBad, errCount, expErr);
    end
    runFrame(16'd4, 32'hA0000000, 0, 1'b0, 1'b1);
    expPkt++;
    checks++;
    if (obsFwd != 4 || obsBad != 0 || obsDone != 1 || obsErr != 0 || pktCount !== 16'(expPkt)) begin
      errors++; $display("FAIL sync_followup: got fwd%0d bad%0d done%0d err%0d pc%0d required 4 0 1 0 %0d",
                         obsFwd, obsBad, obsDone, obsErr, pktCount, expPkt);
    end
  endtask

  task automatic test_length_bounds();
    clearObs();
    sendWord(32'hCAFE0000, 1'b0); sample(32'h0);
    checks++;
    if ({pktErr, errCode} !== 3'b110) begin
      errors++; $display("FAIL len_zero: got err%b code%0d required err1 code2", pktErr, errCode);
    end
    sendWord(32'h00000001, 1'b0); sample(32'h0);
    sendWord(32'h00000002, 1'b1); sample(32'h0);
    sendWord(32'hCAFE017E, 1'b0); sample(32'h0);
    checks++;
    if ({pktErr, errCode} !== 3'b110) begin
      errors++; $display("FAIL len_382: got err%b code%0d required err1 code2", pktErr, errCode);
    end
    for (int i = 0; i < 3; i++) begin
      sendWord(32'hCAFE0001, i == 2); sample(32'h0);
    end
    expErr += 2;
    checks++;
    if (obsFwd != 0 || obsErr != 2 || errCount !== 16'(expErr)) begin
      errors++; $display("FAIL len_drop: got fwd%0d errs%0d ec%0d required 0 2 %0d", obsFwd, obsErr, errCount, expErr);
    end
    runFrame(16'd381, 32'h13570000, 7, 1'b0, 1'b1);
    expPkt++;
    checks++;
    if (obsFwd != 381 || obsBad != 0 || obsLast != 1 || obsDone != 1 || obsErr != 0 || pktCount !== 16'(expPkt)) begin
      errors++; $display("FAIL len_max: got fwd%0d bad%0d last%0d done%0d err%0d pc%0d required 381 0 1 1 0 %0d",
                         obsFwd, obsBad, obsLast, obsDone, obsErr, pktCount, expPkt);
    end
  endtask

  task automatic test_truncation_overrun();
    clearObs();
    sendWord(32'hCAFE0014, 1'b0); sample(32'h0);
    for (int i = 1; i <= 10; i++) begin
      sendWord(32'hD0000000 + 32'(i), i == 10); sample(32'hD0000000 + 32'(i));
    end
    expErr++;
    checks++;
    if ({validOut, lastOut, pktErr, errCode} !== 5'b11110 || dataOut !== 32'hD000000A) begin
      errors++; $display("FAIL trunc_word10: got v%b l%b err%b code%0d %h required v1 l1 err1 code2 D000000A",
                         validOut, lastOut, pktErr, errCode, dataOut);
    end
    checks++;
    if (obsFwd != 10 || obsBad != 0 || obsLast != 1 || obsErr != 1 || errCount !== 16'(expErr)) begin
      errors++; $display("FAIL trunc_totals: got fwd%0d bad%0d last%0d err%0d ec%0d required 10 0 1 1 %0d",
                         obsFwd, obsBad, obsLast, obsErr, errCount, expErr);
    end
    runFrame(16'd2, 32'h0BAD0000, 0, 1'b0, 1'b1);
    expPkt++;
    checks++;
    if (obsDone != 1 || obsErr != 0 || obsFwd != 2 || pktCount !== 16'(expPkt)) begin
      errors++; $display("FAIL trunc_followup: got done%0d err%0d fwd%0d pc%0d required 1 0 2 %0d",
                         obsDone, obsErr, obsFwd, pktCount, expPkt);
    end
    // Overrun: footer position reached without lastIn.
    runFrame(16'd2, 32'h0E000000, 0, 1'b0, 1'b0);
    expErr++;
    checks++;
    if ({pktErr, errCode, pktDone} !== 4'b1100 || errCount !== 16'(expErr)) begin
      errors++; $display("FAIL overrun_pulse: got err%b code%0d done%b ec%0d required err1 code2 done0 ec%0d",
                         pktErr, errCode, pktDone, errCount, expErr);
    end
    clearObs();
    sendWord(32'hCAFE0002, 1'b0); sample(32'h0);
    sendWord(32'h12345678, 1'b1); sample(32'h0);
    checks++;
    if (obsFwd != 0 || obsErr != 0 || obsDone != 0 || errCount !== 16'(expErr)) begin
      errors++; $display("FAIL overrun_drop: got fwd%0d err%0d done%0d ec%0d required 0 0 0 %0d",
                         obsFwd, obsErr, obsDone, errCount, expErr);
    end
    runFrame(16'd3, 32'h0F000000, 0, 1'b0, 1'b1);
    expPkt++;
    checks++;
    if (obsDone != 1 || obsFwd != 3 || pktCount !== 16'(expPkt)) begin
      errors++; $display("FAIL overrun_followup: got done%0d fwd%0d pc%0d required 1 3 %0d",
                         obsDone, obsFwd, pktCount, expPkt);
    end
  endtask

  task automatic test_reset_mid_payload();
    sendWord(32'hCAFE0014, 1'b0);
    for (int i = 1; i <= 4; i++) sendWord(32'hE0000000 + 32'(i), 1'b0);
    @(negedge clock);
    reset   = 1'b1;
    dataIn  = 32'hE0000005;
    validIn = 1'b1;
    lastIn  = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if ({dataOut, validOut, lastOut, pktDone, pktErr, errCode, pktCount, errCount} !== '0) begin
      errors++; $display("FAIL reset_mid: got %h/%b%b%b%b/%0d/%0d/%0d required all zero",
                         dataOut, validOut, lastOut, pktDone, pktErr, errCode, pktCount, errCount);
    end
    @(negedge clock);
    reset   = 1'b0;
    validIn = 1'b0;
    lastIn  = 1'b0;
    expPkt = 0;
    expErr = 0;
    runFrame(16'd5, 32'h77000000, 0, 1'b0, 1'b1);
    expPkt++;
    checks++;
    if (obsDone != 1 || obsErr != 0 || obsFwd != 5 || obsBad != 0 || pktCount !== 16'(expPkt) || errCount !== 16'(expErr)) begin
      errors++; $display("FAIL reset_followup: got done%0d err%0d fwd%0d bad%0d pc%0d ec%0d required 1 0 5 0 1 0",
                         obsDone, obsErr, obsFwd, obsBad, pktCount, errCount);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_checksum_error();
    test_bad_sync();
    test_length_bounds();
    test_truncation_overrun();
    test_reset_mid_payload();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
